// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: control-word layout and architectural constants.
package mips_pkg;

  localparam int unsigned CTRLBITS = 14;

  // Control word bit positions, LSB first.
  localparam int unsigned CTRL_HALT        = 0;
  localparam int unsigned CTRL_USES_RT     = 1;
  localparam int unsigned CTRL_REG_WRITE   = 2;
  localparam int unsigned CTRL_MEM_SIZE_LO = 3;
  localparam int unsigned CTRL_MEM_SIZE_HI = 4;
  localparam int unsigned CTRL_MEM_WRITE   = 5;
  localparam int unsigned CTRL_MEM_READ    = 6;
  localparam int unsigned CTRL_ALU_OP_LO   = 7;
  localparam int unsigned CTRL_ALU_OP_HI   = 10;
  localparam int unsigned CTRL_ALU_SRC     = 11;
  localparam int unsigned CTRL_REG_DST_LO  = 12;
  localparam int unsigned CTRL_REG_DST_HI  = 13;

  typedef struct packed {
    logic [1:0] reg_dst;
    logic       alu_src;
    logic [3:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_size;
    logic       reg_write;
    logic       uses_rt;
    logic       halt;
  } ctrl_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector between the EX-stage load and the ID-stage consumer.
module load_use_detect
  import mips_pkg::*;
#(
  parameter int unsigned RBITS = 5
) (
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [RBITS-1:0] ex_rt,
  input  logic             id_valid,
  input  logic [RBITS-1:0] id_rs,
  input  logic [RBITS-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             stall
);

  logic rs_hit;
  logic rt_hit;

  always_comb begin
    rs_hit = (ex_rt == id_rs);
    rt_hit = id_uses_rt & (ex_rt == id_rt);
    stall  = id_valid & ex_valid & ex_mem_read
           & (ex_rt != RBITS'(REG_ZERO)) & (rs_hit | rt_hit);
  end

endmodule

// File: rtl/id_ex_latch.sv
// ID/EX pipeline register with load-use stall, flush/halt bubbling and a debug bubble counter.
module id_ex_latch
  import mips_pkg::*;
#(
  parameter int unsigned NBITS    = 32,
  parameter int unsigned RBITS    = 5,
  parameter int unsigned CTRLBITS = mips_pkg::CTRLBITS,
  parameter int unsigned CNTBITS  = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_enable,
  input  logic                i_flush,
  input  logic                i_valid,
  input  logic [NBITS-1:0]    i_pc4,
  input  logic [NBITS-1:0]    i_rs_data,
  input  logic [NBITS-1:0]    i_rt_data,
  input  logic [NBITS-1:0]    i_imm_ext,
  input  logic [RBITS-1:0]    i_rs,
  input  logic [RBITS-1:0]    i_rt,
  input  logic [RBITS-1:0]    i_rd,
  input  logic [4:0]          i_shamt,
  input  logic [CTRLBITS-1:0] i_ctrl,
  output logic [NBITS-1:0]    o_pc4,
  output logic [NBITS-1:0]    o_rs_data,
  output logic [NBITS-1:0]    o_rt_data,
  output logic [NBITS-1:0]    o_imm_ext,
  output logic [RBITS-1:0]    o_rs,
  output logic [RBITS-1:0]    o_rt,
  output logic [RBITS-1:0]    o_rd,
  output logic [4:0]          o_shamt,
  output logic [CTRLBITS-1:0] o_ctrl,
  output logic                o_valid,
  output logic                o_stall,
  output logic                o_halted,
  output logic [CNTBITS-1:0]  o_bubble_cnt
);

  logic forced_bubble;
  logic load_real;

  load_use_detect #(
    .RBITS(RBITS)
  ) u_load_use_detect (
    .ex_valid   (o_valid),
    .ex_mem_read(o_ctrl[CTRL_MEM_READ]),
    .ex_rt      (o_rt),
    .id_valid   (i_valid),
    .id_rs      (i_rs),
    .id_rt      (i_rt),
    .id_uses_rt (i_ctrl[CTRL_USES_RT]),
    .stall      (o_stall)
  );

  // A halted pipe swallows everything, so flush/stall no longer count as forcing the bubble.
  always_comb begin
    forced_bubble = ~o_halted & (i_flush | o_stall);
    load_real     = ~o_halted & ~i_flush & ~o_stall & i_valid;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pc4        <= '0;
      o_rs_data    <= '0;
      o_rt_data    <= '0;
      o_imm_ext    <= '0;
      o_rs         <= '0;
      o_rt         <= '0;
      o_rd         <= '0;
      o_shamt      <= '0;
      o_ctrl       <= '0;
      o_valid      <= 1'b0;
      o_halted     <= 1'b0;
      o_bubble_cnt <= '0;
    end else if (i_enable) begin
      o_pc4     <= i_pc4;
      o_rs_data <= i_rs_data;
      o_rt_data <= i_rt_data;
      o_imm_ext <= i_imm_ext;
      o_rs      <= i_rs;
      o_rt      <= i_rt;
      o_rd      <= i_rd;
      o_shamt   <= i_shamt;
      o_valid   <= load_real;
      o_ctrl    <= load_real ? i_ctrl : '0;
      if (load_real && i_ctrl[CTRL_HALT]) begin
        o_halted <= 1'b1;
      end
      if (forced_bubble && i_valid && (o_bubble_cnt != '1)) begin
        o_bubble_cnt <= o_bubble_cnt + CNTBITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_id_ex_latch.sv
// Directed, table-driven bench for the ID/EX pipeline register.
module tb_id_ex_latch;

  localparam logic [13:0] C_ADD  = 14'h1106; // R-type: reg_dst=01, alu_op=0010, reg_write, uses_rt
  localparam logic [13:0] C_LW   = 14'h0844; // alu_src, mem_read, reg_write
  localparam logic [13:0] C_ADDI = 14'h0904; // alu_src, alu_op=0010, reg_write, no uses_rt
  localparam logic [13:0] C_HALT = 14'h0001;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_enable = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_valid = 1'b0;
  logic [31:0] i_pc4 = '0, i_rs_data = '0, i_rt_data = '0, i_imm_ext = '0;
  logic [4:0]  i_rs = '0, i_rt = '0, i_rd = '0, i_shamt = '0;
  logic [13:0] i_ctrl = '0;
  logic [31:0] o_pc4, o_rs_data, o_rt_data, o_imm_ext;
  logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
  logic [13:0] o_ctrl;
  logic        o_valid, o_stall, o_halted;
  logic [15:0] o_bubble_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  id_ex_latch #(
    .NBITS(32), .RBITS(5), .CTRLBITS(14), .CNTBITS(16)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_flush(i_flush),
    .i_valid(i_valid), .i_pc4(i_pc4), .i_rs_data(i_rs_data), .i_rt_data(i_rt_data),
    .i_imm_ext(i_imm_ext), .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_shamt(i_shamt),
    .i_ctrl(i_ctrl), .o_pc4(o_pc4), .o_rs_data(o_rs_data), .o_rt_data(o_rt_data),
    .o_imm_ext(o_imm_ext), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_shamt(o_shamt),
    .o_ctrl(o_ctrl), .o_valid(o_valid), .o_stall(o_stall), .o_halted(o_halted),
    .o_bubble_cnt(o_bubble_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        en, vld, fl;
    logic [4:0]  rs, rt, rd;
    logic [13:0] ctrl;
    logic        exp_stall, exp_valid;
    logic [13:0] exp_ctrl;
    logic [15:0] exp_cnt;
    logic        exp_halt;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(input logic en, vld, fl, input logic [4:0] rs, rt, rd,
                              input logic [13:0] ctrl, input logic es, ev,
                              input logic [13:0] ec, input logic [15:0] ecnt, input logic eh);
    vec_t v;
    v.en = en; v.vld = vld; v.fl = fl; v.rs = rs; v.rt = rt; v.rd = rd; v.ctrl = ctrl;
    v.exp_stall = es; v.exp_valid = ev; v.exp_ctrl = ec; v.exp_cnt = ecnt; v.exp_halt = eh;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " pc4"}, o_pc4, 0);
    chk({tag, " rs_data"}, o_rs_data, 0);
    chk({tag, " rt_data"}, o_rt_data, 0);
    chk({tag, " imm_ext"}, o_imm_ext, 0);
    chk({tag, " regs"}, {17'd0, o_rs, o_rt, o_rd}, 0);
    chk({tag, " shamt"}, {27'd0, o_shamt}, 0);
    chk({tag, " ctrl"}, {18'd0, o_ctrl}, 0);
    chk({tag, " valid"}, {31'd0, o_valid}, 0);
    chk({tag, " halted"}, {31'd0, o_halted}, 0);
    chk({tag, " cnt"}, {16'd0, o_bubble_cnt}, 0);
    chk({tag, " stall"}, {31'd0, o_stall}, 0);
  endtask

  logic [31:0] m_rsd, m_imm, m_pc4;
  logic [4:0]  m_rt, m_rd;

  initial begin
    //            en vld fl  rs  rt  rd  ctrl    | stall valid ctrl  cnt halt
    tbl[0]  = mk(1, 1, 0,  1,  2,  3, C_ADD,  0, 1, C_ADD,  0, 0);
    tbl[1]  = mk(1, 1, 0,  9,  8,  0, C_LW,   0, 1, C_LW,   0, 0);
    tbl[2]  = mk(1, 1, 0,  8,  4,  5, C_ADD,  1, 0, 14'h0,  1, 0);
    tbl[3]  = mk(1, 1, 0,  8,  4,  5, C_ADD,  0, 1, C_ADD,  1, 0);
    tbl[4]  = mk(1, 1, 0,  1,  6,  0, C_LW,   0, 1, C_LW,   1, 0);
    tbl[5]  = mk(1, 1, 0,  2,  6,  0, C_ADDI, 0, 1, C_ADDI, 1, 0);
    tbl[6]  = mk(1, 1, 0,  1,  0,  0, C_LW,   0, 1, C_LW,   1, 0);
    tbl[7]  = mk(1, 1, 0,  0,  0,  6, C_ADD,  0, 1, C_ADD,  1, 0);
    tbl[8]  = mk(1, 1, 0,  2,  8,  0, C_LW,   0, 1, C_LW,   1, 0);
    tbl[9]  = mk(1, 1, 1,  3,  8,  9, C_ADD,  1, 0, 14'h0,  2, 0);
    tbl[10] = mk(1, 1, 0,  1,  7,  0, C_LW,   0, 1, C_LW,   2, 0);
    tbl[11] = mk(0, 1, 0,  1,  7,  2, C_ADD,  1, 1, C_LW,   2, 0);
    tbl[12] = mk(0, 1, 0,  1,  7,  2, C_ADD,  1, 1, C_LW,   2, 0);
    tbl[13] = mk(0, 1, 0,  1,  7,  2, C_ADD,  1, 1, C_LW,   2, 0);
    tbl[14] = mk(1, 1, 0,  1,  7,  2, C_ADD,  1, 0, 14'h0,  3, 0);
    tbl[15] = mk(1, 0, 0,  1,  7,  2, C_ADD,  0, 0, 14'h0,  3, 0);
    tbl[16] = mk(1, 0, 1,  1,  7,  2, C_ADD,  0, 0, 14'h0,  3, 0);
    tbl[17] = mk(1, 1, 0,  0,  0,  0, C_HALT, 0, 1, C_HALT, 3, 1);
    tbl[18] = mk(1, 1, 0,  1,  2,  3, C_ADD,  0, 0, 14'h0,  3, 1);
    tbl[19] = mk(1, 1, 1,  1,  2,  3, C_ADD,  0, 0, 14'h0,  3, 1);

    #2;
    chk_all_zero("reset");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    m_rsd = '0; m_imm = '0; m_pc4 = '0; m_rt = '0; m_rd = '0;

    for (int i = 0; i < 20; i++) begin
      @(posedge i_clk);
      #1;
      i_enable  = tbl[i].en;
      i_valid   = tbl[i].vld;
      i_flush   = tbl[i].fl;
      i_rs      = tbl[i].rs;
      i_rt      = tbl[i].rt;
      i_rd      = tbl[i].rd;
      i_ctrl    = tbl[i].ctrl;
      i_rs_data = (i == 0) ? 32'd5 : 32'd100 + 32'(i);
      i_imm_ext = (i == 0) ? 32'hFFFF_8000 : 32'h0000_1000 + 32'(i);
      i_pc4     = 32'h0040_0000 + 32'(4 * i);
      i_rt_data = 32'hA000_0000 + 32'(i);
      i_shamt   = 5'(i);
      #1;
      chk($sformatf("v%0d stall", i), {31'd0, o_stall}, {31'd0, tbl[i].exp_stall});
      if (tbl[i].en) begin
        m_rsd = i_rs_data; m_imm = i_imm_ext; m_pc4 = i_pc4; m_rt = i_rt; m_rd = i_rd;
      end
      @(posedge i_clk);
      #1;
      chk($sformatf("v%0d valid", i), {31'd0, o_valid}, {31'd0, tbl[i].exp_valid});
      chk($sformatf("v%0d ctrl", i), {18'd0, o_ctrl}, {18'd0, tbl[i].exp_ctrl});
      chk($sformatf("v%0d cnt", i), {16'd0, o_bubble_cnt}, {16'd0, tbl[i].exp_cnt});
      chk($sformatf("v%0d halted", i), {31'd0, o_halted}, {31'd0, tbl[i].exp_halt});
      chk($sformatf("v%0d rs_data", i), o_rs_data, m_rsd);
      chk($sformatf("v%0d imm_ext", i), o_imm_ext, m_imm);
      chk($sformatf("v%0d pc4", i), o_pc4, m_pc4);
      chk($sformatf("v%0d rt/rd", i), {22'd0, o_rt, o_rd}, {22'd0, m_rt, m_rd});
      // Each vector occupies two edges: hold inputs with enable low for the second one.
      i_enable = 1'b0;
    end

    // Asynchronous reset asserted mid-cycle while halted with a non-zero counter.
    @(posedge i_clk);
    #3;
    i_rst_n = 1'b0;
    #2;
    chk_all_zero("midreset");
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Counter saturation: continuous flushed valid instructions.
    i_enable = 1'b1; i_valid = 1'b1; i_flush = 1'b1; i_ctrl = C_ADD;
    repeat (65534) @(posedge i_clk);
    #1;
    chk("sat cnt fffe", {16'd0, o_bubble_cnt}, 32'h0000_FFFE);
    @(posedge i_clk);
    #1;
    chk("sat cnt ffff", {16'd0, o_bubble_cnt}, 32'h0000_FFFF);
    repeat (3) @(posedge i_clk);
    #1;
    chk("sat cnt hold", {16'd0, o_bubble_cnt}, 32'h0000_FFFF);
    chk("sat valid", {31'd0, o_valid}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_latch.md
# id_ex_latch

Pipeline register between the decode stage and the execute stage of the 5-stage MIPS datapath. It captures the decoded operands, the 32-bit sign-extended immediate, register addresses and the control word on each enabled cycle. It detects load-use hazards against the instruction currently in EX and inserts bubbles on stall or flush. It also holds a sticky halt flag and a bubble counter for the debug unit.

## Interface
- NBITS, 32, data/PC width
- RBITS, 5, register address width
- CTRLBITS, 14, control word width (layout in package)
- CNTBITS, 16, bubble counter width

- i_clk  in  1  rising-edge clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_enable  in  1  debug-unit run/step enable; 0 = freeze every register
- i_flush  in  1  branch/jump resolved; squash the incoming instruction
- i_valid  in  1  IF/ID holds a real instruction
- i_pc4  in  NBITS  PC+4 of the decode instruction
- i_rs_data, i_rt_data  in  NBITS  register-file read data
- i_imm_ext  in  NBITS  sign-extended immediate from the extender
- i_rs, i_rt, i_rd  in  RBITS  register addresses
- i_shamt  in  5  shift amount
- i_ctrl  in  CTRLBITS  decoded control word
- o_pc4, o_rs_data, o_rt_data, o_imm_ext  out  NBITS  registered copies
- o_rs, o_rt, o_rd  out  RBITS  registered copies
- o_shamt  out  5  registered copy
- o_ctrl  out  CTRLBITS  registered control word (all zero for a bubble)
- o_valid  out  1  EX slot holds a real instruction
- o_stall  out  1  combinational load-use stall to the PC and IF/ID
- o_halted  out  1  sticky: a HALT has entered EX
- o_bubble_cnt  out  CNTBITS  saturating count of inserted bubbles

## Operation
- Control word fields: reg_dst[1:0], alu_src, alu_op[3:0], mem_read, mem_write, mem_size[1:0], reg_write, uses_rt, halt. The bit positions are defined in the package.
- Load-use hazard: o_stall = i_valid & o_valid & o_ctrl.mem_read & (o_rt != 0) & ((o_rt == i_rs) | (i_ctrl.uses_rt & o_rt == i_rt)).
- Per-edge update, in priority order:
  1. !i_rst_n clears all state.
  2. !i_enable holds all state, including the counter.
  3. o_halted: the load is replaced by a bubble.
  4. i_flush: bubble.
  5. o_stall: bubble.
  6. Otherwise load all inputs, with o_valid = i_valid.
- A bubble sets o_valid = 0 and o_ctrl = 0. Data fields load as normal and are don't-care.
- i_valid = 0 without flush or stall loads a bubble. This does not count as an inserted bubble.
- o_bubble_cnt increments once per enabled edge where flush or stall forced a bubble and i_valid = 1. It saturates at all-ones.
- o_halted sets on the edge that loads a valid instruction with ctrl.halt = 1. It clears only on reset. That HALT instruction itself stays in EX with o_valid = 1.
- Flush and stall in the same cycle produce one bubble and one count.

## Timing
- All outputs except o_stall are registered, with 1-cycle latency from inputs.
- o_stall depends combinationally on the current registers and the ID inputs. It is valid in the same cycle and has no dependence on i_enable.
- A stall lasts exactly one cycle for a single load-use pair. After the bubble, o_ctrl.mem_read = 0, so o_stall drops.
- Reset values: every output register is 0, o_valid = 0, o_halted = 0, o_bubble_cnt = 0. o_stall is therefore 0 out of reset.
- Reset asserted mid-operation clears state immediately, without waiting for the clock.

## Structure
- Shared package `mips_pkg`: CTRLBITS, the control field bit-position constants, and the register-0 constant. Decode and EX import the same package.
- Sub-module `load_use_detect`: purely combinational, computing o_stall from the EX-side rt/mem_read/valid and the ID-side rs/rt/uses_rt/valid.
- The rest is a single always block with asynchronous reset.

## Test plan
- Reset, then load i_imm_ext = 0xFFFF8000 and i_rs_data = 5 with i_valid = 1. After one edge: o_imm_ext = 0xFFFF8000, o_rs_data = 5, o_valid = 1.
- EX holds LW with rt = 8. ID has rs = 8. Response: o_stall = 1 in the same cycle, a bubble next edge (o_ctrl = 0, o_valid = 0), o_bubble_cnt = 1, then o_stall = 0.
- EX holds LW with rt = 0, and ID has rs = 0. Response: o_stall = 0, and ID loads normally.
- i_flush and a stall together for one edge: one bubble, counter +1. With i_enable = 0 for 3 edges: all outputs and the counter are unchanged.
- Load a valid HALT: o_halted = 1, and later valid inputs load as bubbles. Assert i_rst_n = 0 mid-cycle: all outputs read 0 before the next edge.
